// File: rtl/simon_sequence_player_if.sv
// ---------------------------------------------------------------------------
// simon_sequence_player_if
// Control/status bundle between the Simon game state machine (master) and
// the sequence player (slave). Clock and reset travel as plain ports.
// ---------------------------------------------------------------------------
interface simon_sequence_player_if;
    logic       Clear;
    logic       Append;
    logic       Play_Start;
    logic [5:0] Rd_Idx;
    logic [2:0] Rd_Color;
    logic [6:0] Seq_Len;
    logic       Full;
    logic       Play_Busy;
    logic       Play_Done;
    logic [2:0] Color_Out;

    // Game state machine side: issues commands, reads back pattern and status.
    modport master (
        output Clear, Append, Play_Start, Rd_Idx,
        input  Rd_Color, Seq_Len, Full, Play_Busy, Play_Done, Color_Out
    );

    // Sequence player side.
    modport slave (
        input  Clear, Append, Play_Start, Rd_Idx,
        output Rd_Color, Seq_Len, Full, Play_Busy, Play_Done, Color_Out
    );
endinterface

// File: rtl/simon_sequence_player.sv
// ---------------------------------------------------------------------------
// simon_sequence_player
// Holds the Simon colour pattern, appends LFSR-generated colours, serves
// combinational readback by index, and plays the pattern as timed flashes
// (dark gap before each flash and after the last one).
// Colour codes: 0 none, 1 RED, 2 BLUE, 3 YELLOW, 4 GREEN.
// Optional feature macro: SIMON_SPEEDUP_EN -- when defined, flash and gap
// lengths shrink by 2^min(len/8, 3) for longer patterns (floored at 1 cycle).
// ---------------------------------------------------------------------------
module simon_sequence_player #(
    parameter int          MAX_LEN   = 64,
    parameter int          ON_TICKS  = 25000000,
    parameter int          OFF_TICKS = 12500000,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                   Clk,
    input  logic                   Reset,
    simon_sequence_player_if.slave sp_if
);

    localparam int MAX_TICKS = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int TW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
    localparam int AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [1:0] {IDLE, GAP, SHOW, DONE} state_t;

    state_t        state_q;
    logic [15:0]   lfsr_q;
    logic [6:0]    seq_len_q;
    logic          full_q;
    logic [6:0]    idx_q;
    logic [TW-1:0] timer_q;
    logic [2:0]    color_q;
    logic          busy_q;
    logic          done_q;
    logic [2:0]    mem [MAX_LEN];

    logic          append_ok;
    logic [6:0]    len_next;
    logic          start_play;
    logic [2:0]    new_color;
    logic [TW-1:0] start_on_m1;
    logic [TW-1:0] start_off_m1;
    logic [TW-1:0] on_m1;
    logic [TW-1:0] off_m1;

    // Appends land only while idle and not full; Clear drops a coincident append.
    assign append_ok  = sp_if.Append && !sp_if.Clear && (state_q == IDLE) && !full_q;
    assign len_next   = seq_len_q + {6'd0, append_ok};
    assign start_play = sp_if.Play_Start && !sp_if.Clear && (state_q == IDLE)
                        && (len_next != 7'd0);
    assign new_color  = {1'b0, lfsr_q[1:0]} + 3'd1;

`ifdef SIMON_SPEEDUP_EN
    // Returns (ticks >> min(len/8, 3)) - 1, with the shifted length floored at 1.
    function automatic logic [TW-1:0] scaled_m1(input int ticks, input logic [6:0] len);
        int sh;
        int v;
        sh = (len[6:3] > 4'd3) ? 3 : int'({28'd0, len[6:3]});
        v  = ticks >> sh;
        if (v < 1) v = 1;
        return TW'(v - 1);
    endfunction

    logic [TW-1:0] on_m1_q;
    logic [TW-1:0] off_m1_q;

    assign start_on_m1  = scaled_m1(ON_TICKS, len_next);
    assign start_off_m1 = scaled_m1(OFF_TICKS, len_next);
    assign on_m1        = on_m1_q;
    assign off_m1       = off_m1_q;

    // Freeze the scaled flash/gap lengths for the whole playback at start.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            on_m1_q  <= '0;
            off_m1_q <= '0;
        end else if (start_play) begin
            on_m1_q  <= start_on_m1;
            off_m1_q <= start_off_m1;
        end
    end
`else
    assign start_on_m1  = TW'(ON_TICKS - 1);
    assign start_off_m1 = TW'(OFF_TICKS - 1);
    assign on_m1        = start_on_m1;
    assign off_m1       = start_off_m1;
`endif

    // Free-running 16-bit Galois LFSR, x^16+x^14+x^13+x^11.
    always_ff @(posedge Clk or posedge Reset) begin
        // NOTE: sequential state always uses non-blocking (<=) so every register
        // samples the pre-edge values of its neighbours, regardless of block order.
        if (Reset) lfsr_q <= LFSR_SEED;
        else       lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end

    // Pattern memory write port.
    always_ff @(posedge Clk) begin
        // NOTE: the pattern array has no reset; stale entries are invisible
        // because every read is masked by seq_len_q, and a reset would block RAM mapping.
        if (append_ok) mem[seq_len_q[AW-1:0]] <= new_color;
    end

    // Combinational readback, masked to 0 beyond the stored length.
    always_comb begin
        // NOTE: default first so no path leaves the output unassigned (no latch).
        sp_if.Rd_Color = 3'd0;
        if ({1'b0, sp_if.Rd_Idx} < seq_len_q) sp_if.Rd_Color = mem[sp_if.Rd_Idx[AW-1:0]];
    end

    // Playback FSM with pattern length bookkeeping and registered outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            seq_len_q <= 7'd0;
            full_q    <= 1'b0;
            idx_q     <= 7'd0;
            timer_q   <= '0;
            color_q   <= 3'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (sp_if.Clear) begin
                // Abort everything; the LFSR keeps running so the next game differs.
                state_q   <= IDLE;
                seq_len_q <= 7'd0;
                full_q    <= 1'b0;
                idx_q     <= 7'd0;
                timer_q   <= '0;
                color_q   <= 3'd0;
                busy_q    <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (append_ok) begin
                            seq_len_q <= len_next;
                            full_q    <= (seq_len_q == 7'(MAX_LEN - 1));
                        end
                        if (sp_if.Play_Start) begin
                            if (start_play) begin
                                state_q <= GAP;
                                idx_q   <= 7'd0;
                                timer_q <= start_off_m1;
                                busy_q  <= 1'b1;
                            end else begin
                                // Empty pattern: report completion without flashing.
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    GAP: begin
                        if (timer_q != '0) begin
                            timer_q <= timer_q - 1'b1;
                        end else if (idx_q < seq_len_q) begin
                            state_q <= SHOW;
                            timer_q <= on_m1;
                            color_q <= mem[idx_q[AW-1:0]];
                        end else begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                    SHOW: begin
                        if (timer_q != '0) begin
                            timer_q <= timer_q - 1'b1;
                        end else begin
                            state_q <= GAP;
                            idx_q   <= idx_q + 7'd1;
                            timer_q <= off_m1;
                            color_q <= 3'd0;
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign sp_if.Seq_Len   = seq_len_q;
    assign sp_if.Full      = full_q;
    assign sp_if.Play_Busy = busy_q;
    assign sp_if.Play_Done = done_q;
    assign sp_if.Color_Out = color_q;

endmodule

// File: tb/tb_simon_sequence_player.sv
// ---------------------------------------------------------------------------
// tb_simon_sequence_player
// Self-checking bench: a colour queue plus an LFSR rule model predict the
// pattern; playback is predicted as a per-cycle list of expected colours.
// ---------------------------------------------------------------------------
module tb_simon_sequence_player;

    localparam int          MAX_LEN   = 64;
    localparam int          ON_TICKS  = 4;
    localparam int          OFF_TICKS = 2;
    localparam logic [15:0] SEED      = 16'hACE1;

    logic Clk = 1'b0;
    logic Reset;

    simon_sequence_player_if bus();

    simon_sequence_player #(
        .MAX_LEN  (MAX_LEN),
        .ON_TICKS (ON_TICKS),
        .OFF_TICKS(OFF_TICKS),
        .LFSR_SEED(SEED)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .sp_if(bus.slave)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] m_lfsr;
    logic [2:0]  exp_q[$];
    bit          m_idle;

    // Reference LFSR: right-shift Galois form of x^16+x^14+x^13+x^11.
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        logic [15:0] n;
        n = l >> 1;
        if (l[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    always @(posedge Clk or posedge Reset) begin
        if (Reset) m_lfsr <= SEED;
        else       m_lfsr <= lfsr_step(m_lfsr);
    end

    // Flash/gap length for a pattern of n colours.
    function automatic int seg_len(input int ticks, input int n);
        int t;
        t = ticks;
`ifdef SIMON_SPEEDUP_EN
        begin
            int sh;
            sh = n / 8;
            if (sh > 3) sh = 3;
            t = t >> sh;
            if (t < 1) t = 1;
        end
`endif
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // One clock with the given command inputs; the model follows the same rules.
    task automatic cycle(input bit c, input bit a, input bit p);
        logic [2:0] col;
        bus.Clear = c; bus.Append = a; bus.Play_Start = p;
        col = {1'b0, m_lfsr[1:0]} + 3'd1;
        if (c) exp_q.delete();
        else if (a && m_idle && exp_q.size() < MAX_LEN) exp_q.push_back(col);
        tick();
        bus.Clear = 1'b0; bus.Append = 1'b0; bus.Play_Start = 1'b0;
    endtask

    task automatic check_read(input string name, input int idx);
        logic [2:0] e;
        bus.Rd_Idx = 6'(idx);
        #1;
        e = (idx < exp_q.size()) ? exp_q[idx] : 3'd0;
        check(name, bus.Rd_Color, e);
    endtask

    // Start playback and check every cycle of Color_Out/Play_Busy, then Play_Done.
    task automatic play_check(input string name, input bit with_append);
        logic [2:0] seq[$];
        int n, on_l, off_l;
        cycle(1'b0, with_append, 1'b1);
        m_idle = 1'b0;
        n = exp_q.size();
        on_l  = seg_len(ON_TICKS, n);
        off_l = seg_len(OFF_TICKS, n);
        if (n > 0) begin
            for (int i = 0; i < n; i++) begin
                repeat (off_l) seq.push_back(3'd0);
                repeat (on_l) seq.push_back(exp_q[i]);
            end
            repeat (off_l) seq.push_back(3'd0);
            for (int k = 0; k < seq.size(); k++) begin
                check($sformatf("%s busy/colour cyc%0d", name, k),
                      {bus.Play_Busy, bus.Color_Out}, {1'b1, seq[k]});
                tick();
            end
        end
        check({name, " done pulse"}, {bus.Play_Done, bus.Play_Busy, bus.Color_Out}, {1'b1, 1'b0, 3'd0});
        tick();
        check({name, " done cleared"}, {bus.Play_Done, bus.Play_Busy}, 2'b00);
        m_idle = 1'b1;
    endtask

    typedef struct {
        string      name;
        bit         clear, append, play;
        logic [5:0] rd_idx;
        logic [6:0] len;
        bit         busy, done;
        logic [2:0] color, rd_color;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{"empty play",   0, 0, 1, 6'd0,  7'd0, 0, 1, 3'd0, 3'd0};
        tbl[1] = '{"after done",   0, 0, 0, 6'd0,  7'd0, 0, 0, 3'd0, 3'd0};
        tbl[2] = '{"clear+append", 1, 1, 0, 6'd0,  7'd0, 0, 0, 3'd0, 3'd0};
        tbl[3] = '{"append 1",     0, 1, 0, 6'd1,  7'd1, 0, 0, 3'd0, 3'd0};
        tbl[4] = '{"append 2",     0, 1, 0, 6'd2,  7'd2, 0, 0, 3'd0, 3'd0};
        tbl[5] = '{"append+clear", 1, 1, 0, 6'd0,  7'd0, 0, 0, 3'd0, 3'd0};
        tbl[6] = '{"append again", 0, 1, 0, 6'd63, 7'd1, 0, 0, 3'd0, 3'd0};
        tbl[7] = '{"final clear",  1, 0, 0, 6'd0,  7'd0, 0, 0, 3'd0, 3'd0};

        Reset = 1'b1; m_idle = 1'b1;
        bus.Clear = 1'b0; bus.Append = 1'b0; bus.Play_Start = 1'b0; bus.Rd_Idx = 6'd0;
        repeat (3) @(posedge Clk);
        #1;
        check("reset outputs",
              {bus.Seq_Len, bus.Full, bus.Play_Busy, bus.Play_Done, bus.Color_Out}, 0);
        Reset = 1'b0;

        // Three appends, readback against the LFSR model, index past end reads 0.
        repeat (3) cycle(1'b0, 1'b1, 1'b0);
        check("len after 3", bus.Seq_Len, 7'd3);
        for (int i = 0; i < 3; i++) begin
            check_read($sformatf("read idx%0d", i), i);
            check($sformatf("range idx%0d", i), (bus.Rd_Color >= 3'd1 && bus.Rd_Color <= 3'd4), 1);
        end
        check_read("read idx3 past end", 3);
        play_check("play3", 1'b0);

        // Table-driven single-cycle control vectors.
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            bus.Rd_Idx = tbl[i].rd_idx;
            cycle(tbl[i].clear, tbl[i].append, tbl[i].play);
            check({tbl[i].name, " len"}, bus.Seq_Len, tbl[i].len);
            check({tbl[i].name, " busy"}, bus.Play_Busy, tbl[i].busy);
            check({tbl[i].name, " done"}, bus.Play_Done, tbl[i].done);
            check({tbl[i].name, " colour"}, bus.Color_Out, tbl[i].color);
            check({tbl[i].name, " rd"}, bus.Rd_Color, tbl[i].rd_color);
        end

        // Fill to MAX_LEN, then an extra append is ignored.
        repeat (MAX_LEN) cycle(1'b0, 1'b1, 1'b0);
        check("len full", bus.Seq_Len, 7'd64);
        check("full flag", bus.Full, 1'b1);
        for (int i = 0; i < MAX_LEN; i++) check_read($sformatf("full read%0d", i), i);
        cycle(1'b0, 1'b1, 1'b0);
        check("len after 65th", bus.Seq_Len, 7'd64);
        check_read("last entry kept", 63);

        // Append and Play_Start while busy are ignored.
        begin
            int busy_cnt;
            bit seen_done;
            cycle(1'b1, 1'b0, 1'b0);
            repeat (2) cycle(1'b0, 1'b1, 1'b0);
            cycle(1'b0, 1'b0, 1'b1);
            m_idle = 1'b0;
            busy_cnt = 0;
            seen_done = 1'b0;
            cycle(1'b0, 1'b1, 1'b1);
            busy_cnt = 1;
            check("len ignores busy append", bus.Seq_Len, 7'd2);
            for (int k = 0; k < 200 && !seen_done; k++) begin
                if (bus.Play_Done) seen_done = 1'b1;
                else begin
                    if (bus.Play_Busy) busy_cnt++;
                    tick();
                end
            end
            check("busy-append done seen", seen_done, 1'b1);
            check("busy-append duration", busy_cnt,
                  2 * (seg_len(ON_TICKS, 2) + seg_len(OFF_TICKS, 2)) + seg_len(OFF_TICKS, 2));
            tick();
            m_idle = 1'b1;
            check_read("busy-append kept idx1", 1);
        end

        // Clear (with append) in the middle of a flash.
        begin
            bit found, saw_done;
            cycle(1'b1, 1'b0, 1'b0);
            repeat (3) cycle(1'b0, 1'b1, 1'b0);
            cycle(1'b0, 1'b0, 1'b1);
            m_idle = 1'b0;
            found = 1'b0;
            for (int k = 0; k < 20 && !found; k++) begin
                if (bus.Color_Out != 3'd0) found = 1'b1;
                else tick();
            end
            check("flash reached", found, 1'b1);
            tick();
            check("still showing", bus.Color_Out, exp_q[0]);
            m_idle = 1'b1;
            cycle(1'b1, 1'b1, 1'b0);
            check("clear mid-show",
                  {bus.Seq_Len, bus.Play_Busy, bus.Play_Done, bus.Color_Out}, 0);
            saw_done = 1'b0;
            repeat (8) begin
                if (bus.Play_Done || bus.Play_Busy) saw_done = 1'b1;
                tick();
            end
            check("no done after clear", saw_done, 1'b0);
        end

        // Append together with Play_Start: playback uses the new length.
        cycle(1'b0, 1'b1, 1'b0);
        play_check("append+start", 1'b1);

        // Eight colours (speed-up threshold when enabled).
        cycle(1'b1, 1'b0, 1'b0);
        repeat (8) cycle(1'b0, 1'b1, 1'b0);
        play_check("play8", 1'b0);

        // Randomized rounds.
        for (int r = 0; r < 6; r++) begin
            int n;
            cycle(1'b1, 1'b0, 1'b0);
            n = $urandom_range(1, 10);
            for (int i = 0; i < n; i++) begin
                repeat ($urandom_range(0, 2)) cycle(1'b0, 1'b0, 1'b0);
                cycle(1'b0, 1'b1, 1'b0);
            end
            check($sformatf("rnd%0d len", r), bus.Seq_Len, 7'(exp_q.size()));
            for (int j = 0; j < 4; j++)
                check_read($sformatf("rnd%0d read", r), int'($urandom_range(0, 15)));
            play_check($sformatf("rnd%0d play", r), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of playback.
        repeat (2) cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        repeat (7) tick();
        Reset = 1'b1;
        #1;
        check("async reset mid-play",
              {bus.Seq_Len, bus.Full, bus.Play_Busy, bus.Play_Done, bus.Color_Out}, 0);
        exp_q.delete();
        m_idle = 1'b1;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        cycle(1'b0, 1'b1, 1'b0);
        check_read("reseeded colour", 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/simon_sequence_player.md
Name: simon_sequence_player

Overview:
- Owns the Simon colour pattern memory and plays the pattern back to the player as timed colour flashes.
- The game state machine appends one random colour per round and requests playback. It then reads entries back by index to compare against button input.
- Colour codes match the game state machine: 0 = none, 1 = RED, 2 = BLUE, 3 = YELLOW, 4 = GREEN.
- Color_Out drives the LED/VGA colour layer.

Parameters:
- MAX_LEN, 64, pattern memory depth; must be a power of 2, at most 64.
- ON_TICKS, 25000000, Clk cycles per colour flash.
- OFF_TICKS, 12500000, Clk cycles of dark gap before each flash and after the last flash.
- LFSR_SEED, 16'hACE1, LFSR value loaded on Reset; must be nonzero.

Ports:
- Clk  input  1  system clock.
- Reset  input  1  asynchronous, active-high reset.
- Clear  input  1  start a new game: empty the pattern and abort any playback.
- Append  input  1  one-cycle request to add one random colour at the end of the pattern.
- Play_Start  input  1  one-cycle request to play the whole pattern.
- Rd_Idx  input  6  readback index.
- Rd_Color  output  3  combinational colour at Rd_Idx; 0 if Rd_Idx >= Seq_Len.
- Seq_Len  output  7  number of stored colours, 0..MAX_LEN.
- Full  output  1  high when Seq_Len == MAX_LEN.
- Play_Busy  output  1  high while playback is in progress.
- Play_Done  output  1  one-cycle pulse when playback completes.
- Color_Out  output  3  colour currently shown; 0 when dark.

Behaviour:
- Reset values:
  - Seq_Len=0, Color_Out=0, Play_Busy=0, Play_Done=0.
  - State=IDLE, LFSR=LFSR_SEED, timer=0, play index=0.
  - Memory contents are don't-care, masked by Seq_Len.
- LFSR:
  - 16-bit Galois, taps x^16+x^14+x^13+x^11, free-runs every cycle including during Reset release.
  - New colour = LFSR[1:0] + 1, taken from the current register value.
- Append:
  - Honoured only in IDLE with Full=0.
  - Writes mem[Seq_Len]; Seq_Len increments the next cycle.
  - Ignored when Full=1 or when not in IDLE. No error flag.
- States: IDLE, GAP, SHOW, DONE.
- IDLE:
  - Play_Start with Seq_Len>0: go to GAP, index=0, timer=OFF_TICKS-1; Play_Busy rises the next cycle.
  - Play_Start with Seq_Len==0: go to DONE directly; no flash.
  - Append and Play_Start in the same cycle: the append is performed and playback uses the new length.
- GAP:
  - Color_Out=0. Timer counts down to 0.
  - If index < Seq_Len: go to SHOW, timer=ON_TICKS-1.
  - Else: go to DONE.
- SHOW:
  - Color_Out=mem[index]. Timer counts down to 0.
  - Then index+1, go to GAP, timer=OFF_TICKS-1.
- DONE:
  - Play_Done=1 and Play_Busy=0 for exactly one cycle, then IDLE.
- Playback timing:
  - N = Seq_Len captured at start.
  - Play_Busy is high for exactly N*(ON_TICKS+OFF_TICKS)+OFF_TICKS cycles, followed immediately by the Play_Done pulse.
- Play_Start while busy: ignored.
- Clear:
  - Highest priority in any state.
  - Next cycle: Seq_Len=0, state IDLE, Color_Out=0, Play_Busy=0.
  - No Play_Done pulse. The LFSR is not reseeded.
  - Clear with Append in the same cycle: Clear wins and the append is dropped.
- Reset mid-playback: all outputs return to reset values asynchronously.
- Rd_Color is readable at any time, including during playback.
- Timer width is $clog2 of the larger of ON_TICKS and OFF_TICKS.
- All outputs are registered except Rd_Color.

Optional Feature:
- Macro: SIMON_SPEEDUP_EN.
- Defined:
  - Flash length at playback start is ON_TICKS >> min(Seq_Len/8, 3).
  - Gap length is OFF_TICKS >> min(Seq_Len/8, 3).
  - Each shifted value is floored at 1.
  - Busy duration follows the formula above using the shifted values.
- Undefined: fixed ON_TICKS and OFF_TICKS.

Test Plan (ON_TICKS=4, OFF_TICKS=2, LFSR_SEED=16'hACE1):
- Reset, then 3 Append pulses -> Seq_Len=3; Rd_Color for idx 0..2 matches the LFSR model, each value in 1..4; Rd_Idx=3 returns 0.
- Seq_Len=3, Play_Start -> Play_Busy high 20 cycles; Color_Out sequence is 2x0, 4xc0, 2x0, 4xc1, 2x0, 4xc2, 2x0; then one Play_Done pulse.
- Seq_Len=0, Play_Start -> Play_Done pulses the next cycle; Play_Busy never rises; Color_Out stays 0.
- 64 Appends, then a 65th -> Full=1, Seq_Len=64, memory unchanged; Append during playback is ignored.
- Mid-SHOW Clear -> next cycle Color_Out=0, Play_Busy=0, Seq_Len=0, no Play_Done; Clear together with Append leaves Seq_Len=0.
- SIMON_SPEEDUP_EN defined, Seq_Len=8 -> flash 2 cycles, gap 1 cycle, Busy for 8*3+1=25 cycles.
